pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the ALU stage. Each cycle it decides whether the decode-stage instruction issues into the
//  ALU, and selects operand forwarding for rs/rt. It stalls on load-use hazards. It runs the late-branch
//  and exception redirect handshake with fetch and returns br_late_done to the ALU.
//  Sits between decode, the ALU stage and fetch.
// PARAMETERS
//  EXC_VECTOR     32'h80000180  PC fetch is redirected to when the ALU raises an exception
//  REDIR_TIMEOUT  15            max cycles to wait for redirect_ack before raising redirect_err (4-bit cnt)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous, active-low reset (0 = reset, sampled on posedge clk)
//  dec_valid      in   1   decode holds a valid instruction
//  dec_rs_index   in   5   rs read by decode instruction
//  dec_rt_index   in   5   rt read by decode instruction
//  dec_rd_index   in   5   final destination of decode instruction (0 = no write)
//  dec_is_load    in   1   decode instruction is lw
//  dec_stall      out  1   hold fetch/decode this cycle (comb)
//  alu_issue      out  1   decode instruction enters ALU at this posedge (comb)
//  fwd_rs_sel     out  2   0 regfile, 1 ALU-stage result, 2 MEM-stage result (comb)
//  fwd_rt_sel     out  2   same encoding for rt
//  br_late_enable in   1   from ALU: late branch taken
//  br_target      in   32  from ALU: branch target
//  alu_exception  in   3   from ALU: nonzero = exception
//  alu_pc         in   32  PC of the instruction in ALU (EPC capture)
//  redirect_valid out  1   request fetch to load redirect_pc
//  redirect_pc    out  32  redirect address
//  redirect_ack   in   1   fetch accepted redirect
//  br_late_done   out  1   one-cycle pulse to ALU: redirect complete
//  epc            out  32  PC of last excepting instruction
//  redirect_err   out  1   sticky: redirect timed out
// BEHAVIOUR
//  Reset (rst=0): state IDLE. Shadow regs ex_rd/mem_rd = 0, ex_load/mem_load = 0.
//   redirect_valid=0, redirect_pc=0, br_late_done=0, epc=0, redirect_err=0, timeout counter 0.
//  Shadow pipeline, on every posedge out of reset:
//   - mem_* <= ex_*.
//   - ex_* <= dec_* if alu_issue, else ex_* <= 0 (bubble).
//  Forwarding for rs (rt identical), index 0 never matches:
//   - rs==ex_rd and !ex_load -> sel 1.
//   - else rs==mem_rd -> sel 2.
//   - else sel 0.
//   ex match has priority over mem match.
//  Load-use: dec_valid and (rs or rt)==ex_rd with ex_load -> dec_stall=1, alu_issue=0 for exactly one cycle.
//   Next cycle the load sits in mem_* and forwards with sel 2.
//  alu_issue = dec_valid & !dec_stall. dec_stall = load_use | (state==REDIR) | (state==FLUSH).
//  FSM states: IDLE, DSLOT, REDIR, FLUSH.
//   - IDLE: on alu_exception!=0, go REDIR. Also:
//       redirect_pc <= EXC_VECTOR, epc <= alu_pc.
//       Clear ex_* and mem_* (squash younger and older-in-flight writers).
//     Exception wins over a simultaneous br_late_enable.
//   - IDLE: else on br_late_enable, go DSLOT and redirect_pc <= br_target.
//   - DSLOT: the delay-slot instruction issues normally (the stall rules above still apply).
//     On the first posedge with alu_issue=1, go REDIR.
//     An exception in DSLOT takes the IDLE exception path and overrides the branch target.
//   - REDIR: redirect_valid=1. Counter increments each cycle.
//       redirect_ack -> go FLUSH, clear counter.
//       Counter reaching REDIR_TIMEOUT -> set redirect_err and go FLUSH anyway.
//   - FLUSH: one cycle. br_late_done=1. The decode instruction (wrong path) is dropped (alu_issue=0).
//     Then go IDLE.
//  br_late_enable seen outside IDLE/DSLOT is ignored. The ALU cannot raise one while waiting.
//  Reset mid-operation: returns to IDLE with no br_late_done pulse. Any pending redirect is abandoned.
// TESTING
//  add r3 issued, next insn reads r3 -> fwd_rs_sel=1 that cycle; one cycle later an unrelated reader of r3 gets sel 2.
//  lw r5 then add r6,r5,r1 -> dec_stall=1 for exactly 1 cycle, then alu_issue=1 with fwd_rs_sel=2.
//  br_late_enable with br_target=32'h400 -> DSLOT insn issues; redirect_valid=1 with pc 0x400.
//   ack after 3 cycles -> br_late_done pulse the next cycle, wrong-path insn not issued.
//  alu_exception=3'b010 with br_late_enable=1 at alu_pc=32'h1000 -> redirect_pc=32'h80000180, epc=32'h1000.
//   Forwarding sel 0 for prior rds.
//  No redirect_ack for REDIR_TIMEOUT cycles -> redirect_err=1 (sticky), FSM returns to IDLE via FLUSH.
//  rst=0 asserted while in REDIR -> next cycle all outputs at reset values, no br_late_done pulse.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ALU-stage sequencer: issue/stall decision, rs/rt forwarding select, and the
// late-branch / exception redirect handshake with fetch.
module pipeline_hazard_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h80000180,
    parameter int unsigned REDIR_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs_index,
    input  logic [4:0]  dec_rt_index,
    input  logic [4:0]  dec_rd_index,
    input  logic        dec_is_load,
    output logic        dec_stall,
    output logic        alu_issue,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    input  logic        br_late_enable,
    input  logic [31:0] br_target,
    input  logic [2:0]  alu_exception,
    input  logic [31:0] alu_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack,
    output logic        br_late_done,
    output logic [31:0] epc,
    output logic        redirect_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned REG_W = 5;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_ALU = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSLOT = 2'd1,
        REDIR = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [REG_W-1:0]   ex_rd;
    logic [REG_W-1:0]   mem_rd;
    logic               ex_load;
    logic               mem_load;
    logic [CNT_W-1:0]   redir_cnt;

    logic               exc_take;
    logic               redir_timeout;
    logic               load_use;
    logic               busy;

    // ALU-stage result wins over MEM; a load still in ALU cannot forward yet.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] idx,
        input logic [REG_W-1:0] e_rd,
        input logic             e_ld,
        input logic [REG_W-1:0] m_rd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (idx != '0) begin
            if (idx == e_rd && !e_ld) begin
                sel = SEL_ALU;
            end else if (idx == m_rd) begin
                sel = SEL_MEM;
            end
        end
        return sel;
    endfunction

    assign exc_take      = (state == IDLE || state == DSLOT) && (alu_exception != 3'd0);
    assign redir_timeout = (redir_cnt == CNT_W'(REDIR_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (exc_take) begin
                    state_next = REDIR;
                end else if (br_late_enable) begin
                    state_next = DSLOT;
                end
            end
            DSLOT: begin
                if (exc_take || alu_issue) begin
                    state_next = REDIR;
                end
            end
            REDIR: begin
                if (redirect_ack || redir_timeout) begin
                    state_next = FLUSH;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: issue/stall, forwarding and handshake strobes.
    always_comb begin
        busy           = (state == REDIR) || (state == FLUSH);
        load_use       = dec_valid && ex_load && (ex_rd != '0) &&
                         ((dec_rs_index == ex_rd) || (dec_rt_index == ex_rd));
        dec_stall      = load_use || busy;
        alu_issue      = dec_valid && !dec_stall;
        fwd_rs_sel     = fwd_sel(dec_rs_index, ex_rd, ex_load, mem_rd);
        fwd_rt_sel     = fwd_sel(dec_rt_index, ex_rd, ex_load, mem_rd);
        redirect_valid = (state == REDIR);
        br_late_done   = (state == FLUSH);
    end

    // Shadow pipeline, redirect address/EPC capture, timeout counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_rd        <= '0;
            mem_rd       <= '0;
            ex_load      <= 1'b0;
            mem_load     <= 1'b0;
            redirect_pc  <= '0;
            epc          <= '0;
            redirect_err <= 1'b0;
            redir_cnt    <= '0;
        end else begin
            if (exc_take) begin
                ex_rd       <= '0;
                ex_load     <= 1'b0;
                mem_rd      <= '0;
                mem_load    <= 1'b0;
                redirect_pc <= EXC_VECTOR;
                epc         <= alu_pc;
            end else begin
                mem_rd   <= ex_rd;
                mem_load <= ex_load;
                ex_rd    <= alu_issue ? dec_rd_index : '0;
                ex_load  <= alu_issue && dec_is_load;
                if (state == IDLE && br_late_enable) begin
                    redirect_pc <= br_target;
                end
            end

            if (state == REDIR && !(redirect_ack || redir_timeout)) begin
                redir_cnt <= redir_cnt + CNT_W'(1);
            end else begin
                redir_cnt <= '0;
            end

            if (state == REDIR && !redirect_ack && redir_timeout) begin
                redirect_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random
// traffic, checked against an instruction-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] EXC_VEC = 32'h80000180;
    localparam int          TMO     = 15;

    typedef struct {
        bit          rst;
        bit          dv;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        bit          ld;
        bit          br;
        logic [31:0] tgt;
        logic [2:0]  exc;
        logic [31:0] pc;
        bit          ack;
    } stim_t;

    typedef struct {
        logic        stall;
        logic        issue;
        logic [1:0]  fs;
        logic [1:0]  ft;
        logic        rv;
        logic [31:0] rpc;
        logic        done;
        logic [31:0] epc;
        logic        err;
    } exp_t;

    typedef struct {
        logic [4:0] rd;
        bit         ld;
    } insn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  dec_rs_index, dec_rt_index, dec_rd_index;
    logic        dec_is_load;
    logic        dec_stall, alu_issue;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic        br_late_enable;
    logic [31:0] br_target;
    logic [2:0]  alu_exception;
    logic [31:0] alu_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic        br_late_done;
    logic [31:0] epc;
    logic        redirect_err;

    int checks = 0;
    int fails  = 0;
    exp_t sb[$];

    // Reference model: the two instructions in flight plus the redirect transaction.
    insn_t       m_alu, m_mem;
    bit          m_br_pending, m_redir, m_flush, m_err;
    int          m_wait;
    logic [31:0] m_rpc, m_epc;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs_index(dec_rs_index),
        .dec_rt_index(dec_rt_index), .dec_rd_index(dec_rd_index),
        .dec_is_load(dec_is_load), .dec_stall(dec_stall), .alu_issue(alu_issue),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .br_late_enable(br_late_enable), .br_target(br_target),
        .alu_exception(alu_exception), .alu_pc(alu_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ack(redirect_ack), .br_late_done(br_late_done),
        .epc(epc), .redirect_err(redirect_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_alu = '{rd: 5'd0, ld: 1'b0};
        m_mem = '{rd: 5'd0, ld: 1'b0};
        m_br_pending = 0; m_redir = 0; m_flush = 0; m_err = 0;
        m_wait = 0; m_rpc = '0; m_epc = '0;
    endtask

    function automatic logic [1:0] producer(input logic [4:0] idx);
        if (idx == 0) return 2'd0;
        if (m_alu.rd == idx && !m_alu.ld) return 2'd1;
        if (m_mem.rd == idx) return 2'd2;
        return 2'd0;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{rst: 1, dv: 0, rs: 0, rt: 0, rd: 0, ld: 0, br: 0,
              tgt: 0, exc: 0, pc: 0, ack: 0};
        return s;
    endfunction

    function automatic stim_t insn(input int rs, input int rt, input int rd, input bit ld);
        stim_t s;
        s = nop();
        s.dv = 1; s.rs = 5'(rs); s.rt = 5'(rt); s.rd = 5'(rd); s.ld = ld;
        return s;
    endfunction

    // Apply one cycle of stimulus, predict the outputs it sees, then advance the model.
    task automatic cycle(input stim_t s);
        exp_t  e;
        bit    hazard, issue;
        @(posedge clk);
        #1;
        rst = s.rst; dec_valid = s.dv; dec_rs_index = s.rs; dec_rt_index = s.rt;
        dec_rd_index = s.rd; dec_is_load = s.ld; br_late_enable = s.br;
        br_target = s.tgt; alu_exception = s.exc; alu_pc = s.pc; redirect_ack = s.ack;

        hazard  = s.dv && m_alu.ld && m_alu.rd != 0 && (s.rs == m_alu.rd || s.rt == m_alu.rd);
        e.stall = hazard || m_redir || m_flush;
        issue   = s.dv && !e.stall;
        e.issue = issue;
        e.fs    = producer(s.rs);
        e.ft    = producer(s.rt);
        e.rv    = m_redir;
        e.rpc   = m_rpc;
        e.done  = m_flush;
        e.epc   = m_epc;
        e.err   = m_err;
        sb.push_back(e);

        if (!s.rst) begin
            model_reset();
        end else begin
            m_mem = m_alu;
            m_alu = issue ? '{rd: s.rd, ld: s.ld} : '{rd: 5'd0, ld: 1'b0};
            if (m_flush) begin
                m_flush = 0;
            end else if (m_redir) begin
                m_wait++;
                if (s.ack || m_wait == TMO) begin
                    if (!s.ack) m_err = 1;
                    m_redir = 0; m_flush = 1; m_wait = 0;
                end
            end else if (s.exc != 0) begin
                m_alu = '{rd: 5'd0, ld: 1'b0};
                m_mem = '{rd: 5'd0, ld: 1'b0};
                m_rpc = EXC_VEC; m_epc = s.pc;
                m_redir = 1; m_br_pending = 0; m_wait = 0;
            end else if (m_br_pending) begin
                if (issue) begin
                    m_br_pending = 0; m_redir = 1; m_wait = 0;
                end
            end else if (s.br) begin
                m_br_pending = 1; m_rpc = s.tgt;
            end
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a response, compare against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("dec_stall",      32'(dec_stall),      32'(e.stall));
            chk("alu_issue",      32'(alu_issue),      32'(e.issue));
            chk("fwd_rs_sel",     32'(fwd_rs_sel),     32'(e.fs));
            chk("fwd_rt_sel",     32'(fwd_rt_sel),     32'(e.ft));
            chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
            chk("redirect_pc",    redirect_pc,         e.rpc);
            chk("br_late_done",   32'(br_late_done),   32'(e.done));
            chk("epc",            epc,                 e.epc);
            chk("redirect_err",   32'(redirect_err),   32'(e.err));
        end
    end

    initial begin
        stim_t s;
        bit    quiet_ack;
        model_reset();
        rst = 1'b0; dec_valid = 0; dec_rs_index = 0; dec_rt_index = 0; dec_rd_index = 0;
        dec_is_load = 0; br_late_enable = 0; br_target = 0; alu_exception = 0;
        alu_pc = 0; redirect_ack = 0;
        @(posedge clk);
        s = nop(); s.rst = 0;
        cycle(s);
        cycle(s);

        // ALU then MEM forwarding of r3.
        cycle(insn(1, 2, 3, 0));
        cycle(insn(3, 1, 4, 0));
        cycle(insn(3, 0, 7, 0));
        cycle(nop());
        // Load-use on r5.
        cycle(insn(1, 2, 5, 1));
        cycle(insn(5, 1, 6, 0));
        cycle(insn(5, 1, 6, 0));
        cycle(nop());
        // Late branch to 0x400, delay slot, ack after 3 cycles, wrong-path drop.
        s = nop(); s.br = 1; s.tgt = 32'h400;
        cycle(s);
        cycle(insn(1, 2, 8, 0));
        repeat (3) cycle(insn(9, 9, 9, 0));
        s = insn(9, 9, 9, 0); s.ack = 1;
        cycle(s);
        cycle(insn(9, 9, 9, 0));
        cycle(nop());
        // Exception beats simultaneous branch; prior writers squashed.
        cycle(insn(0, 0, 3, 0));
        cycle(insn(0, 0, 4, 0));
        s = insn(3, 4, 10, 0); s.exc = 3'b010; s.br = 1; s.tgt = 32'h2000; s.pc = 32'h1000;
        cycle(s);
        cycle(insn(3, 4, 10, 0));
        s = nop(); s.ack = 1;
        cycle(s);
        cycle(nop());
        cycle(insn(3, 4, 11, 0));
        // Redirect timeout.
        s = nop(); s.br = 1; s.tgt = 32'h500;
        cycle(s);
        cycle(insn(1, 1, 1, 0));
        repeat (TMO + 3) cycle(nop());
        // Reset while waiting for ack.
        s = nop(); s.br = 1; s.tgt = 32'h600;
        cycle(s);
        cycle(insn(2, 2, 2, 0));
        cycle(nop());
        s = nop(); s.rst = 0;
        cycle(s);
        repeat (3) cycle(nop());

        // Random traffic; one window withholds ack to force timeouts.
        for (int i = 0; i < 3000; i++) begin
            quiet_ack = (i >= 1000 && i < 1100);
            s.rst = ($urandom_range(0, 149) != 0);
            s.dv  = ($urandom_range(0, 3) != 0);
            s.rs  = 5'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.ld  = ($urandom_range(0, 2) == 0);
            s.br  = ($urandom_range(0, 7) == 0);
            s.tgt = $urandom;
            s.exc = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            s.pc  = $urandom;
            s.ack = !quiet_ack && ($urandom_range(0, 2) == 0);
            cycle(s);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
